dmem_avalon_bridge: RTL and testbench
=====================================

# dmem_avalon_bridge

Data-memory bus bridge sitting directly downstream of the store write-mask stage in the MEM stage of the 64-bit RISC-V core. Accepts one load or store per request, drives a single Avalon-MM master port to the on-chip data memory, holds the pipeline with `stall` until the bus transaction completes, and returns byte-aligned, sign- or zero-extended load data. Stores arrive with byteenable and write data already lane-shifted, and are passed through unchanged.

## Interface
- `N`, 64, data width in bits; the block supports only 64, with 8 byte lanes.
- `ADDR_W`, 32, Avalon address width in bits.
- `clk`  in  1  clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  memory request present; held stable by the pipeline while `stall`=1.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  N  byte address.
- `req_funct3`  in  3  RISC-V size/sign code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU.
- `req_byteenable`  in  8  lane-shifted store byte mask from the write-mask stage.
- `req_wdata`  in  N  lane-shifted store data.
- `stall`  out  1  freeze the pipeline.
- `rdata`  out  N  aligned, extended load result.
- `rdata_valid`  out  1  one-cycle pulse when `rdata` is updated.
- `misalign`  out  1  one-cycle misaligned-access pulse; only present with the macro.
- `avm_address`  out  ADDR_W  8-byte-aligned address, `{req_addr[ADDR_W-1:3],3'b0}`.
- `avm_read`, `avm_write`  out  1  Avalon commands.
- `avm_byteenable`  out  8  byte mask. Stores carry the registered request mask; loads drive 8'hFF.
- `avm_writedata`  out  N  registered store data.
- `avm_readdata`  in  N  read data.
- `avm_waitrequest`  in  1  slave not ready; the command must be held.
- `avm_readdatavalid`  in  1  read data valid.

## Operation
- **States:** IDLE, WRITE, RD_CMD, RD_WAIT, DONE.
- **IDLE:**
  - When `req_valid`=1, register the address, funct3, byteenable, data and write flag.
  - Go to WRITE if `req_write`=1, otherwise RD_CMD.
  - `stall` = `req_valid` while in IDLE. This is a combinational path and is intended.
- **WRITE:**
  - `avm_write`=1 with the address, byteenable and data from the registers.
  - Hold all of these while `avm_waitrequest`=1.
  - Go to DONE on the first cycle with `avm_waitrequest`=0.
- **RD_CMD:**
  - `avm_read`=1, `avm_byteenable`=8'hFF.
  - Go to RD_WAIT on the first cycle with `avm_waitrequest`=0.
  - `avm_readdatavalid` is ignored in this state; slave read latency is at least 1.
- **RD_WAIT:** on `avm_readdatavalid`=1, capture the extracted load data into `rdata` and go to DONE.
- **Load extraction:**
  - Shift right: `shifted = avm_readdata >> {addr[2:0],3'b0}`.
  - Bit 2 of funct3 = 0: sign-extend from bit 7 / 15 / 31 for funct3[1:0] = 00 / 01 / 10. The value 11 passes all 64 bits.
  - Bit 2 of funct3 = 1: zero-extend.
- **DONE:**
  - `stall`=0 for one cycle; the pipeline advances at this edge.
  - `rdata_valid`=1 for a completed load only.
  - `req_valid` is ignored in DONE; return to IDLE.
- **Hold behaviour:**
  - `rdata` holds its value until the next load completes.
  - `avm_read` and `avm_write` are never both 1.
  - Both are 0 in IDLE, RD_WAIT and DONE.
- **Reset:**
  - Outputs: state=IDLE; `avm_read`, `avm_write`, `avm_address`, `avm_byteenable`, `avm_writedata`, `rdata`, `rdata_valid`, `misalign` all 0.
  - Reset mid-transaction aborts it at the edge, so commands drop the following cycle.
  - A stale `avm_readdatavalid` arriving in IDLE after reset is ignored.

## Timing
- Store with no waitrequest:
  - Cycle 0: IDLE, request accepted, `stall`=1.
  - Cycle 1: WRITE, `stall`=1.
  - Cycle 2: DONE, `stall`=0.
  - Each waitrequest cycle adds 1.
- Load with no waitrequest and readdatavalid latency L (L≥1):
  - Accept at cycle 0, RD_CMD at cycle 1.
  - `avm_readdatavalid` arrives at cycle 1+L.
  - DONE at cycle 2+L, with `rdata` and `rdata_valid` visible in that cycle.
- One transaction at a time; no pipelining of requests.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - In IDLE, a request is misaligned when any of these holds:
    - funct3[1:0]=01 and addr[0]≠0
    - funct3[1:0]=10 and addr[1:0]≠0
    - funct3[1:0]=11 and addr[2:0]≠0
  - A misaligned request goes straight to DONE with no bus command.
  - In DONE: `misalign`=1 for that cycle, `rdata_valid`=0, `rdata` unchanged. Total stall is 1 cycle.
- Macro undefined:
  - No check is made and the `misalign` port is absent.
  - Misaligned accesses are issued as-is. Lanes shifted past byte 7 are lost, matching the truncation already done by the mask stage.

## Test plan
- **SD, no waitrequest:** addr 0x1000, byteenable 0xFF, data 0x1122334455667788 → `avm_write` high in cycle 1 with address 0x1000; `stall` high in cycles 0–1 and low in cycle 2.
- **SB under waitrequest:** addr 0x1005, byteenable 0x20, waitrequest high for 3 cycles → write data, byteenable and address held stable through all 4 WRITE cycles; DONE after the 4th.
- **LB:** addr 0x2003, readdata 0x00000000_80000000, L=2 → `rdata` 0xFFFFFFFFFFFFFF80 with `rdata_valid` pulse at cycle 4. The same access as LBU → 0x0000000000000080.
- **LW:** addr 0x2004, readdata 0x89ABCDEF_00000000 → `rdata` 0xFFFFFFFF89ABCDEF. The same access as LWU → 0x0000000089ABCDEF.
- **Reset mid-load:** reset during RD_WAIT, then `avm_readdatavalid`=1 one cycle after reset is released → state IDLE, `rdata`=0, no `rdata_valid`.
- **With `DMEM_MISALIGN_TRAP_EN`:** LW at 0x2002 → no `avm_read`; `misalign` pulses in cycle 1, `stall` high only in cycle 0.

Source files
------------

// File: rtl/dmem_avalon_bridge.sv
// MEM-stage data-memory bridge: one load/store per request onto an Avalon-MM master, stalling
// the pipeline until done. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module dmem_avalon_bridge #(
   parameter int unsigned N      = 64,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [N-1:0]      req_addr,
   input  logic [2:0]        req_funct3,
   input  logic [7:0]        req_byteenable,
   input  logic [N-1:0]      req_wdata,
   output logic              stall,
   output logic [N-1:0]      rdata,
   output logic              rdata_valid,
`ifdef DMEM_MISALIGN_TRAP_EN
   output logic              misalign,
`endif
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [7:0]        avm_byteenable,
   output logic [N-1:0]      avm_writedata,
   input  logic [N-1:0]      avm_readdata,
   input  logic              avm_waitrequest,
   input  logic              avm_readdatavalid
);

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRdCmd,
      StRdWait,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [2:0]          funct3_q;
   logic [7:0]          be_q;
   logic [N-1:0]        wdata_q;
   logic                write_q;
   logic [N-1:0]        rdata_q;
   logic [N-1:0]        shifted;
   logic [N-1:0]        load_data;
   logic                mis_req;
   logic                mis_done;
   logic                accept;

   // Address bits above the Avalon address width never reach the bus.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[N-1:ADDR_W];

   assign accept = (state_q == StIdle) && req_valid;

`ifdef DMEM_MISALIGN_TRAP_EN
   logic mis_q;

   always_comb begin
      mis_req = 1'b0;
      unique case (req_funct3[1:0])
         2'b01:   mis_req = req_addr[0];
         2'b10:   mis_req = |req_addr[1:0];
         2'b11:   mis_req = |req_addr[2:0];
         default: mis_req = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mis_q <= 1'b0;
      end else if (accept) begin
         mis_q <= mis_req;
      end
   end

   assign mis_done = (state_q == StDone) && mis_q;
   assign misalign = mis_done;
`else
   assign mis_req  = 1'b0;
   assign mis_done = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      stall     = 1'b1;
      avm_read  = 1'b0;
      avm_write = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Combinational so the request is frozen in the same cycle it appears.
            stall = req_valid;
            if (req_valid) begin
               if (mis_req) begin
                  state_d = StDone;
               end else if (req_write) begin
                  state_d = StWrite;
               end else begin
                  state_d = StRdCmd;
               end
            end
         end
         StWrite: begin
            avm_write = 1'b1;
            if (!avm_waitrequest) begin
               state_d = StDone;
            end
         end
         StRdCmd: begin
            avm_read = 1'b1;
            if (!avm_waitrequest) begin
               state_d = StRdWait;
            end
         end
         StRdWait: begin
            if (avm_readdatavalid) begin
               state_d = StDone;
            end
         end
         StDone: begin
            stall   = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      shifted   = avm_readdata >> {addr_q[2:0], 3'b000};
      load_data = shifted;
      case (funct3_q)
         3'b000:  load_data = {{(N-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{(N-16){shifted[15]}}, shifted[15:0]};
         3'b010:  load_data = {{(N-32){shifted[31]}}, shifted[31:0]};
         3'b100:  load_data = {{(N-8){1'b0}}, shifted[7:0]};
         3'b101:  load_data = {{(N-16){1'b0}}, shifted[15:0]};
         3'b110:  load_data = {{(N-32){1'b0}}, shifted[31:0]};
         default: load_data = shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         funct3_q <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q   <= req_addr[ADDR_W-1:0];
            funct3_q <= req_funct3;
            be_q     <= req_write ? req_byteenable : 8'hFF;
            wdata_q  <= req_wdata;
            write_q  <= req_write;
         end
         if ((state_q == StRdWait) && avm_readdatavalid) begin
            rdata_q <= load_data;
         end
      end
   end

   assign avm_address    = {addr_q[ADDR_W-1:3], 3'b000};
   assign avm_byteenable = be_q;
   assign avm_writedata  = wdata_q;
   assign rdata          = rdata_q;
   assign rdata_valid    = (state_q == StDone) && !write_q && !mis_done;

endmodule

// File: tb/tb_dmem_avalon_bridge.sv
// Randomized self-checking bench for dmem_avalon_bridge with a reactive Avalon slave and a
// byte-level load-extraction reference model.
module tb_dmem_avalon_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [63:0] req_addr;
   logic [2:0]  req_funct3;
   logic [7:0]  req_byteenable;
   logic [63:0] req_wdata;
   logic        stall;
   logic [63:0] rdata;
   logic        rdata_valid;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic        misalign;
`endif
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [7:0]  avm_byteenable;
   logic [63:0] avm_writedata;
   logic [63:0] avm_readdata;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] model_rdata = '0;

   always #5 clk = ~clk;

   dmem_avalon_bridge #(
      .N      (64),
      .ADDR_W (32)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_write         (req_write),
      .req_addr          (req_addr),
      .req_funct3        (req_funct3),
      .req_byteenable    (req_byteenable),
      .req_wdata         (req_wdata),
      .stall             (stall),
      .rdata             (rdata),
      .rdata_valid       (rdata_valid),
`ifdef DMEM_MISALIGN_TRAP_EN
      .misalign          (misalign),
`endif
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_byteenable    (avm_byteenable),
      .avm_writedata     (avm_writedata),
      .avm_readdata      (avm_readdata),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdatavalid (avm_readdatavalid)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference load result: pick the addressed bytes, then sign- or zero-extend.
   function automatic logic [63:0] extract(input logic [63:0] w, input logic [63:0] a,
                                           input logic [2:0] f3);
      int          nbytes;
      int          off;
      logic [63:0] v;
      logic [63:0] m;
      nbytes = 1 << f3[1:0];
      off    = int'(a[2:0]);
      v      = w >> (8 * off);
      if (nbytes < 8) begin
         m = (64'd1 << (8 * nbytes)) - 64'd1;
         v = v & m;
         if (!f3[2] && v[8*nbytes-1]) v = v | ~m;
      end
      return v;
   endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic [63:0] a, input logic [2:0] f3);
      int nbytes;
      nbytes = 1 << f3[1:0];
      return (int'(a[2:0]) % nbytes) != 0;
   endfunction
`endif

   task automatic do_txn(input logic wr, input logic [63:0] addr, input logic [2:0] f3,
                         input logic [7:0] be, input logic [63:0] wd, input int nwait,
                         input int lat, input logic [63:0] rword);
      int          exp_done;
      int          exp_cmds;
      int          c;
      int          wait_left;
      int          rdv_at;
      int          cmd_cycles;
      logic        mis;
      logic        done;
      logic [63:0] exp_rdata;
      logic [63:0] exp_addr;

      mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis = is_misaligned(addr, f3);
`endif
      if (mis)     exp_done = 1;
      else if (wr) exp_done = 2 + nwait;
      else         exp_done = 2 + nwait + lat;
      exp_cmds  = mis ? 0 : nwait + 1;
      exp_rdata = (!wr && !mis) ? extract(rword, addr, f3) : model_rdata;
      exp_addr  = {32'd0, addr[31:3], 3'b000};

      req_valid         = 1'b1;
      req_write         = wr;
      req_addr          = addr;
      req_funct3        = f3;
      req_byteenable    = be;
      req_wdata         = wd;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      #1;
      check_eq("stall_accept", stall, 1);
      step();

      c          = 1;
      wait_left  = nwait;
      rdv_at     = -1;
      cmd_cycles = 0;
      done       = 1'b0;
      while (!done && c < 200) begin
         avm_waitrequest   = 1'b0;
         avm_readdatavalid = 1'b0;
         avm_readdata      = {$urandom, $urandom};
         check_eq("rd_wr_excl", avm_read & avm_write, 0);
         if (avm_write || avm_read) begin
            cmd_cycles++;
            check_eq("cmd_kind", avm_write, wr);
            check_eq("avm_address", avm_address, exp_addr);
            check_eq("avm_byteenable", avm_byteenable, wr ? be : 8'hFF);
            if (wr) check_eq("avm_writedata", avm_writedata, wd);
            if (avm_read) avm_readdatavalid = 1'($urandom);  // ignored while commanding
            avm_waitrequest = (wait_left > 0);
            if (wait_left > 0) wait_left--;
            else if (avm_read) rdv_at = c + lat;
         end
         if (c == rdv_at) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = rword;
         end
         if (!stall) begin
            done      = 1'b1;
            req_valid = 1'b0;
            check_eq("done_cycle", 64'(c), 64'(exp_done));
            check_eq("cmd_cycles", 64'(cmd_cycles), 64'(exp_cmds));
            check_eq("rdata", rdata, exp_rdata);
            check_eq("rdata_valid", rdata_valid, !wr && !mis);
`ifdef DMEM_MISALIGN_TRAP_EN
            check_eq("misalign", misalign, mis);
`endif
         end else begin
            check_eq("rdata_valid_early", rdata_valid, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
            check_eq("misalign_early", misalign, 0);
`endif
         end
         step();
         c++;
      end
      if (!done) begin
         check_eq("timeout", 0, 1);
         req_valid = 1'b0;
         reset     = 1'b1;
         step();
         step();
         reset       = 1'b0;
         model_rdata = '0;
      end else begin
         model_rdata = exp_rdata;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid         = 1'b0;
         avm_readdatavalid = 1'($urandom);
         avm_waitrequest   = 1'($urandom);
         avm_readdata      = {$urandom, $urandom};
         #1;
         check_eq("idle_stall", stall, 0);
         check_eq("idle_cmd", avm_read | avm_write, 0);
         check_eq("idle_rdata_valid", rdata_valid, 0);
         check_eq("idle_rdata", rdata, model_rdata);
         step();
      end
   endtask

   initial begin
      logic        wr;
      logic [2:0]  f3;
      logic [63:0] addr;

      reset             = 1'b1;
      req_valid         = 1'b0;
      req_write         = 1'b0;
      req_addr          = '0;
      req_funct3        = '0;
      req_byteenable    = '0;
      req_wdata         = '0;
      avm_readdata      = '0;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      step();
      step();
      check_eq("rst_stall", stall, 0);
      check_eq("rst_cmd", {avm_read, avm_write}, 0);
      check_eq("rst_address", avm_address, 0);
      check_eq("rst_byteenable", avm_byteenable, 0);
      check_eq("rst_writedata", avm_writedata, 0);
      check_eq("rst_rdata", rdata, 0);
      check_eq("rst_rdata_valid", rdata_valid, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
      check_eq("rst_misalign", misalign, 0);
`endif
      reset = 1'b0;
      idle_cycles(1);

      // Directed cases.
      do_txn(1'b1, 64'h1000, 3'b011, 8'hFF, 64'h1122334455667788, 0, 1, '0);
      do_txn(1'b1, 64'h1005, 3'b000, 8'h20, 64'h0000_AA00_0000_0000, 3, 1, '0);
      do_txn(1'b0, 64'h2003, 3'b000, 8'h00, '0, 0, 2, 64'h0000_0000_8000_0000);
      check_eq("lb_const", rdata, 64'hFFFF_FFFF_FFFF_FF80);
      do_txn(1'b0, 64'h2003, 3'b100, 8'h00, '0, 0, 2, 64'h0000_0000_8000_0000);
      check_eq("lbu_const", rdata, 64'h0000_0000_0000_0080);
      do_txn(1'b0, 64'h2004, 3'b010, 8'h00, '0, 1, 3, 64'h89AB_CDEF_0000_0000);
      check_eq("lw_const", rdata, 64'hFFFF_FFFF_89AB_CDEF);
      do_txn(1'b0, 64'h2004, 3'b110, 8'h00, '0, 0, 1, 64'h89AB_CDEF_0000_0000);
      check_eq("lwu_const", rdata, 64'h0000_0000_89AB_CDEF);
      do_txn(1'b1, 64'h1008, 3'b010, 8'h0F, 64'h0, 2, 1, '0);
      check_eq("rdata_hold", rdata, 64'h0000_0000_89AB_CDEF);
`ifdef DMEM_MISALIGN_TRAP_EN
      do_txn(1'b0, 64'h2002, 3'b010, 8'h00, '0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("mis_rdata_kept", rdata, 64'h0000_0000_89AB_CDEF);
`endif

      // Reset during RD_WAIT, stale readdatavalid one cycle after release.
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = 64'h3000;
      req_funct3 = 3'b011;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      step();
      check_eq("rst_mid_rdcmd", avm_read, 1);
      req_valid = 1'b0;
      step();
      check_eq("rst_mid_rdwait", {avm_read, stall}, 2'b01);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("rst_mid_cmd_drop", avm_read | avm_write, 0);
      check_eq("rst_mid_rdata", rdata, 0);
      step();
      avm_readdatavalid = 1'b1;
      avm_readdata      = 64'hDEAD_BEEF_CAFE_F00D;
      #1;
      check_eq("rst_stale_stall", stall, 0);
      step();
      avm_readdatavalid = 1'b0;
      check_eq("rst_stale_rdata", rdata, 0);
      check_eq("rst_stale_valid", rdata_valid, 0);
      check_eq("rst_stale_cmd", avm_read | avm_write, 0);
      model_rdata = '0;

      // Randomized traffic.
      for (int t = 0; t < 300; t++) begin
         wr   = 1'($urandom);
         f3   = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
         addr = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) addr[2:0] = addr[2:0] & ~((3'd1 << f3[1:0]) - 3'd1);
         do_txn(wr, addr, f3, 8'($urandom), {$urandom, $urandom}, $urandom_range(0, 3),
                $urandom_range(1, 4), {$urandom, $urandom});
         idle_cycles($urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
